// File: rtl/divider.sv
// Iterative radix-2 restoring divider producing one quotient bit per clock.
// Signed and unsigned modes; divide-by-zero and overflow follow RISC-V M-extension results.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;    // partial remainder
    logic [WIDTH-1:0] acc_q;    // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_q;    // divisor magnitude
    logic             q_neg;
    logic             r_neg;

    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   trial;

    assign dividend_neg = is_signed & dividend[WIDTH-1];
    assign divisor_neg  = is_signed & divisor[WIDTH-1];
    assign dividend_mag = dividend_neg ? -dividend : dividend;
    assign divisor_mag  = divisor_neg  ? -divisor  : divisor;

    // The partial remainder is always below the divisor, so one extra bit is
    // enough for the trial result's sign to say whether the subtraction fit.
    assign trial = {rem_q, acc_q[WIDTH-1]} - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and checked first, so it also aborts an operation in flight.
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            dvs_q       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            done        <= 1'b1;
                        end else if (is_signed && dividend == MIN_VAL && divisor == '1) begin
                            quotient    <= dividend;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            acc_q       <= dividend_mag;
                            dvs_q       <= divisor_mag;
                            rem_q       <= '0;
                            q_neg       <= dividend_neg ^ divisor_neg;
                            r_neg       <= dividend_neg;
                            cnt         <= CNT_LAST;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                            state       <= ITER;
                        end
                    end
                end
                ITER: begin
                    if (trial[WIDTH]) begin
                        rem_q <= {rem_q[WIDTH-2:0], acc_q[WIDTH-1]};
                    end else begin
                        rem_q <= trial[WIDTH-1:0];
                    end
                    acc_q <= {acc_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    quotient  <= q_neg ? -acc_q : acc_q;
                    remainder <= r_neg ? -rem_q : rem_q;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: arithmetic reference model with per-cycle compare,
// directed cases with literal results, and a randomized stream including stray starts and resets.
module tb_divider;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           dbz;
        bit           ovf;
        bit           special;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int checks = 0;
    int failures = 0;

    divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference division from plain integer arithmetic.
    function automatic res_t ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t   res;
        longint sa;
        longint sb;
        res = '0;
        if (b == '0) begin
            res.q = '1;
            res.r = a;
            res.dbz = 1'b1;
            res.special = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            res.q = W'(sa / sb);
            res.r = W'(sa % sb);
            res.ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
            res.special = res.ovf;
        end else begin
            res.q = a / b;
            res.r = a % b;
        end
        return res;
    endfunction

    // Transaction-level model: an accepted normal op completes W+1 edges after acceptance.
    res_t         in_res;
    res_t         p_res;
    bit           model_valid = 1'b0;
    bit           m_pending = 1'b0;
    bit           m_done_now = 1'b0;
    int           m_done_edge = 0;
    int           cyc = 0;
    logic [W-1:0] h_q = '0;
    logic [W-1:0] h_r = '0;
    bit           h_dbz = 1'b0;
    bit           h_ovf = 1'b0;

    always_comb in_res = ref_div(is_signed, dividend, divisor);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        m_done_now <= 1'b0;
        if (!rst_n) begin
            model_valid <= 1'b1;
            m_pending   <= 1'b0;
            h_q         <= '0;
            h_r         <= '0;
            h_dbz       <= 1'b0;
            h_ovf       <= 1'b0;
        end else if (m_pending) begin
            if (cyc + 1 == m_done_edge) begin
                m_pending  <= 1'b0;
                m_done_now <= 1'b1;
                h_q        <= p_res.q;
                h_r        <= p_res.r;
                h_dbz      <= p_res.dbz;
                h_ovf      <= p_res.ovf;
            end
        end else if (start) begin
            if (in_res.special) begin
                m_done_now <= 1'b1;
                h_q        <= in_res.q;
                h_r        <= in_res.r;
                h_dbz      <= in_res.dbz;
                h_ovf      <= in_res.ovf;
            end else begin
                p_res       <= in_res;
                m_pending   <= 1'b1;
                m_done_edge <= cyc + 1 + W + 1;
                h_dbz       <= 1'b0;
                h_ovf       <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("busy", 64'(busy), 64'(m_pending));
            check("done", 64'(done), 64'(m_done_now));
            check("quotient", 64'(quotient), 64'(h_q));
            check("remainder", 64'(remainder), 64'(h_r));
            check("div_by_zero", 64'(div_by_zero), 64'(h_dbz));
            check("overflow", 64'(overflow), 64'(h_ovf));
        end
    end

    // One directed operation; optionally pokes start with other operands while busy.
    task automatic run_op(input string name, input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                          input bit exp_dbz, input bit exp_ovf, input int exp_lat, input bit poke);
        int lat;
        @(negedge clk);
        start = 1'b1;
        is_signed = sgn;
        dividend = a;
        divisor = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            if (poke && lat >= 3 && lat <= 24 && lat % 3 == 0) begin
                start = 1'b1;
                is_signed = $urandom_range(0, 1);
                dividend = $urandom;
                divisor = $urandom_range(0, 3);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({name, ".latency"}, 64'(lat), 64'(exp_lat));
        check({name, ".quotient"}, 64'(quotient), 64'(exp_q));
        check({name, ".remainder"}, 64'(remainder), 64'(exp_r));
        check({name, ".div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
        check({name, ".overflow"}, 64'(overflow), 64'(exp_ovf));
    endtask

    task automatic check_cleared(input string name);
        check({name, ".busy"}, 64'(busy), 64'd0);
        check({name, ".done"}, 64'(done), 64'd0);
        check({name, ".quotient"}, 64'(quotient), 64'd0);
        check({name, ".remainder"}, 64'(remainder), 64'd0);
        check({name, ".div_by_zero"}, 64'(div_by_zero), 64'd0);
        check({name, ".overflow"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        int waited;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_cleared("reset");

        run_op("u_basic", 1'b0, 32'h0000_827D, 32'h0000_00FF, 32'h0000_0083, 32'h0, 1'b0, 1'b0, 34, 1'b0);
        run_op("u_large", 1'b0, 32'h03FF_C005, 32'h0000_1FFF, 32'h0000_1FFF, 32'h4, 1'b0, 1'b0, 34, 1'b1);
        run_op("s_neg7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 34, 1'b0);
        run_op("s_7_neg2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 1'b0, 34, 1'b0);
        run_op("u_max_2", 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 34, 1'b0);
        run_op("dbz_u", 1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1, 1'b0);
        run_op("dbz_s", 1'b1, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1, 1'b0);
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1, 1'b0);
        run_op("u_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 34, 1'b0);

        // Reset during ITER discards the operation.
        @(negedge clk);
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'd100;
        divisor = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_cleared("mid_reset");
        repeat (40) @(negedge clk);
        check_cleared("mid_reset_hold");
        run_op("after_reset", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34, 1'b0);

        // Random stream: starts in any state, including on the done cycle and while busy.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 2) == 0) begin
                start = 1'b1;
                is_signed = $urandom_range(0, 1);
                dividend = $urandom;
                divisor = $urandom;
                case ($urandom_range(0, 7))
                    0: divisor = '0;
                    1: begin dividend = 32'h8000_0000; divisor = '1; end
                    2: divisor = $urandom_range(1, 15);
                    3: dividend = $urandom_range(0, 1000);
                    4: divisor = '1;
                    default: ;
                endcase
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        waited = 0;
        while (m_pending && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("drain_timeout", 64'(m_pending), 64'd0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
